// File: rtl/multicycle_addsub.sv
// multicycle_addsub: WIDTH-bit add/subtract computed CHUNK bits per clock.
// A 1-bit carry register links consecutive chunks, keeping the carry chain
// only CHUNK+1 bits long. Operands are captured once at the accepting edge;
// the result and flags are published together with a one-cycle done pulse.
module multicycle_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ready,
  input  logic             sub,
  input  logic [WIDTH-1:0] inp1,
  input  logic [WIDTH-1:0] inp2,
  input  logic             cin,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state_q, state_d;

  // Latched operands (B already inverted for subtraction) and sign bits
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  // Chunk sequencing: counter, inter-chunk carry, partial result
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] res_q, res_d;
  // Published result and flags
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] b_eff;
  logic [CHUNK-1:0] a_slice [N];
  logic [CHUNK-1:0] b_slice [N];
  logic [CHUNK-1:0] a_cur;
  logic [CHUNK-1:0] b_cur;
  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] res_merge;
  logic             last_chunk;

  assign b_eff      = sub ? ~inp2 : inp2;
  assign last_chunk = (cnt_q == LAST);

  // Split operands into chunks; merge the freshly computed chunk into the
  // partial result at the position selected by the counter.
  for (genvar gi = 0; gi < N; gi++) begin : g_chunk
    assign a_slice[gi] = a_q[gi*CHUNK +: CHUNK];
    assign b_slice[gi] = b_q[gi*CHUNK +: CHUNK];
    assign res_merge[gi*CHUNK +: CHUNK] =
      (cnt_q == CW'(gi)) ? chunk_sum[CHUNK-1:0] : res_q[gi*CHUNK +: CHUNK];
  end

  // Pick the current chunk of each operand and add it with the carry register
  always_comb begin
    a_cur = '0;
    b_cur = '0;
    for (int i = 0; i < N; i++) begin
      if (cnt_q == CW'(i)) begin
        a_cur = a_slice[i];
        b_cur = b_slice[i];
      end
    end
    chunk_sum = {1'b0, a_cur} + {1'b0, b_cur} + {{CHUNK{1'b0}}, carry_q};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: IDLE -> RUN on start, RUN -> DONE after the last chunk
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_chunk) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: capture on accept, accumulate in RUN, publish at end
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = inp1;
          b_d     = b_eff;
          a_msb_d = inp1[WIDTH-1];
          b_msb_d = b_eff[WIDTH-1];
          carry_d = sub | cin;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        res_d   = res_merge;
        carry_d = chunk_sum[CHUNK];
        cnt_d   = cnt_q + CW'(1);
        if (last_chunk) begin
          sum_d  = res_merge;
          cout_d = chunk_sum[CHUNK];
          ovf_d  = (a_msb_q == b_msb_q) && (res_merge[WIDTH-1] != a_msb_q);
          zero_d = (res_merge == '0);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset clears everything including published outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  // Output decode straight from the state and result registers
  always_comb begin
    ready    = (state_q == S_IDLE);
    done     = (state_q == S_DONE);
    sum      = sum_q;
    cout     = cout_q;
    overflow = ovf_q;
    zero     = zero_q;
  end

endmodule

// File: tb/tb_multicycle_addsub.sv
// Scoreboard bench for multicycle_addsub: a default 32/8 instance runs the
// directed scenarios plus random traffic; three 16-bit instances (CHUNK 1, 4,
// 16) run random traffic. Expected results come from a signed/unsigned
// arithmetic model and are checked by per-instance monitors.
module tb_multicycle_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          due;
  } exp_t;

  // Reference: plain modular and signed arithmetic on w-bit operands
  function automatic exp_t model(int w, logic [31:0] a, logic [31:0] b,
                                 logic s, logic c, int due);
    exp_t e;
    longint unsigned mask, ua, ub, t;
    longint sa, sb, r, lim;
    mask = (64'd1 << w) - 64'd1;
    ua   = {32'b0, a} & mask;
    ub   = {32'b0, b} & mask;
    sa   = a[w-1] ? longint'(ua) - (longint'(1) << w) : longint'(ua);
    sb   = b[w-1] ? longint'(ub) - (longint'(1) << w) : longint'(ub);
    lim  = longint'(1) << (w - 1);
    r    = s ? (sa - sb) : (sa + sb + longint'(c));
    if (s) begin
      t      = (ua - ub) & mask;
      e.cout = (ua >= ub);
    end else begin
      t      = ua + ub + 64'(c);
      e.cout = t[w];
      t      = t & mask;
    end
    e.sum  = t[31:0];
    e.zero = (t == 64'd0);
    e.ovf  = (r >= lim) || (r < -lim);
    e.due  = due;
    return e;
  endfunction

  task automatic check(string nm, logic [63:0] act, logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  // ---------------- default 32/8 instance ----------------
  logic        rst, start, ready, sub, cin, done, cout, overflow, zero;
  logic [31:0] inp1, inp2, sum;
  exp_t        mq[$];

  multicycle_addsub #(.WIDTH(32), .CHUNK(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready), .sub(sub),
    .inp1(inp1), .inp2(inp2), .cin(cin), .done(done), .sum(sum),
    .cout(cout), .overflow(overflow), .zero(zero)
  );

  // Issue one operation at a negedge; optionally schedule its expected result
  task automatic issue(logic [31:0] a, logic [31:0] b, logic s, logic c, logic expect_done);
    int t;
    t = 0;
    @(negedge clk);
    while (!ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL m32 ready_timeout: got ready=0 required ready=1 within 100 cycles");
    end
    inp1  = a;
    inp2  = b;
    sub   = s;
    cin   = c;
    start = 1'b1;
    if (expect_done) mq.push_back(model(32, a, b, s, c, cyc + 1 + 4));
    @(negedge clk);
    start = 1'b0;
    inp1  = $urandom;
    inp2  = $urandom;
    sub   = 1'($urandom_range(0, 1));
    cin   = 1'($urandom_range(0, 1));
  endtask

  // Monitor: pop on done, otherwise require outputs to hold the last result
  initial begin : mon32
    exp_t e;
    exp_t hold;
    hold = '{default: 0};
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        mq.delete();
        hold = '{default: 0};
      end else if (done) begin
        check("m32 ready_in_done", 64'(ready), 64'd0);
        if (mq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL m32 unexpected_done: got done=1 required no pending operation");
        end else begin
          e = mq.pop_front();
          check("m32 sum", 64'(sum), 64'(e.sum));
          check("m32 cout", 64'(cout), 64'(e.cout));
          check("m32 overflow", 64'(overflow), 64'(e.ovf));
          check("m32 zero", 64'(zero), 64'(e.zero));
          check("m32 latency_cycle", 64'(cyc), 64'(e.due));
          hold = e;
          $display("txn m32 cyc=%0d sum=%h cout=%0d ovf=%0d zero=%0d",
                   cyc, sum, cout, overflow, zero);
        end
      end else begin
        check("m32 hold_sum", 64'(sum), 64'(hold.sum));
        check("m32 hold_cout", 64'(cout), 64'(hold.cout));
        check("m32 hold_overflow", 64'(overflow), 64'(hold.ovf));
        check("m32 hold_zero", 64'(zero), 64'(hold.zero));
      end
    end
  end

  // ---------------- 16-bit parameter sweep instances ----------------
  for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
    localparam int CH = (gi == 0) ? 1 : ((gi == 1) ? 4 : 16);
    localparam int NC = 16 / CH;
    logic        s_rst, s_start, s_ready, s_sub, s_cin, s_done, s_cout, s_ovf, s_zero;
    logic [15:0] s_a, s_b, s_sum;
    exp_t        sq[$];
    bit          fin = 1'b0;

    multicycle_addsub #(.WIDTH(16), .CHUNK(CH)) u_dut (
      .clk(clk), .rst(s_rst), .start(s_start), .ready(s_ready), .sub(s_sub),
      .inp1(s_a), .inp2(s_b), .cin(s_cin), .done(s_done), .sum(s_sum),
      .cout(s_cout), .overflow(s_ovf), .zero(s_zero)
    );

    initial begin : drv
      int t;
      logic [15:0] a, b;
      logic s, c;
      s_rst = 1'b1; s_start = 1'b0; s_sub = 1'b0; s_cin = 1'b0;
      s_a = '0; s_b = '0;
      repeat (2) @(negedge clk);
      s_rst = 1'b0;
      for (int k = 0; k < 20; k++) begin
        a = 16'($urandom);
        b = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
        s = 1'($urandom_range(0, 1));
        c = 1'($urandom_range(0, 1));
        t = 0;
        while (!s_ready && t < 100) begin
          @(negedge clk);
          t++;
        end
        if (!s_ready) begin
          n_cmp++;
          n_err++;
          $display("FAIL w16c%0d ready_timeout: got ready=0 required ready=1", CH);
        end
        s_a = a; s_b = b; s_sub = s; s_cin = c; s_start = 1'b1;
        sq.push_back(model(16, {16'b0, a}, {16'b0, b}, s, c, cyc + 1 + NC));
        @(negedge clk);
        s_start = 1'b0;
        s_a = 16'($urandom);
        s_b = 16'($urandom);
      end
      t = 0;
      while ((sq.size() != 0 || !s_ready) && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (sq.size() != 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL w16c%0d drain_timeout: got %0d pending required 0", CH, sq.size());
      end
      fin = 1'b1;
    end

    initial begin : mon
      exp_t e;
      exp_t hold;
      hold = '{default: 0};
      forever begin
        @(posedge clk);
        #1;
        if (s_rst) begin
          sq.delete();
          hold = '{default: 0};
        end else if (s_done) begin
          if (sq.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL w16c%0d unexpected_done: got done=1 required none pending", CH);
          end else begin
            e = sq.pop_front();
            check($sformatf("w16c%0d sum", CH), 64'(s_sum), 64'(e.sum[15:0]));
            check($sformatf("w16c%0d cout", CH), 64'(s_cout), 64'(e.cout));
            check($sformatf("w16c%0d overflow", CH), 64'(s_ovf), 64'(e.ovf));
            check($sformatf("w16c%0d zero", CH), 64'(s_zero), 64'(e.zero));
            check($sformatf("w16c%0d latency_cycle", CH), 64'(cyc), 64'(e.due));
            hold = e;
            $display("txn w16c%0d cyc=%0d sum=%h cout=%0d ovf=%0d zero=%0d",
                     CH, cyc, s_sum, s_cout, s_ovf, s_zero);
          end
        end else begin
          check($sformatf("w16c%0d hold_sum", CH), 64'(s_sum), 64'(hold.sum[15:0]));
        end
      end
    end
  end

  // ---------------- directed + random sequence for the 32/8 instance ----------------
  initial begin : main
    int t;
    logic [31:0] a, b;
    rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0;
    inp1 = '0; inp2 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset ready", 64'(ready), 64'd1);
    check("reset done", 64'(done), 64'd0);
    check("reset sum", 64'(sum), 64'd0);
    check("reset flags", {61'd0, cout, overflow, zero}, 64'd0);

    issue(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1);  // wraparound to zero
    issue(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1);  // signed overflow
    issue(32'd5, 32'd7, 1'b1, 1'b1, 1'b1);          // borrow, cin ignored
    issue(32'h8000_0000, 32'd1, 1'b1, 1'b0, 1'b1);  // sub overflow

    // Extra start during RUN must be ignored; operands change mid-flight
    issue(32'd3, 32'd4, 1'b0, 1'b0, 1'b1);
    check("hs ready_run1", 64'(ready), 64'd0);
    start = 1'b1; inp1 = 32'd10; inp2 = 32'd10;
    @(negedge clk);
    check("hs ready_run2", 64'(ready), 64'd0);
    start = 1'b0; inp1 = 32'd99;
    @(negedge clk);
    check("hs ready_run3", 64'(ready), 64'd0);

    // Reset on the second RUN cycle aborts without a done pulse
    issue(32'd100, 32'd200, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort ready", 64'(ready), 64'd1);
    check("abort done", 64'(done), 64'd0);
    check("abort sum", 64'(sum), 64'd0);
    check("abort flags", {61'd0, cout, overflow, zero}, 64'd0);
    issue(32'd1, 32'd1, 1'b0, 1'b0, 1'b1);

    for (int k = 0; k < 30; k++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      issue(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    end

    t = 0;
    while ((mq.size() != 0 || !ready) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (mq.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL m32 drain_timeout: got %0d pending required 0", mq.size());
    end

    t = 0;
    while (!(g_sweep[0].fin && g_sweep[1].fin && g_sweep[2].fin) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (!(g_sweep[0].fin && g_sweep[1].fin && g_sweep[2].fin)) begin
      n_cmp++;
      n_err++;
      $display("FAIL sweep_timeout: got unfinished sweep required all finished");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_addsub.md
Name: multicycle_addsub

Overview:
Parametrised, multi-cycle add/subtract unit for the multi-cycle datapath. It computes a WIDTH-bit sum or difference CHUNK bits per clock, using a registered carry between chunks. This trades latency for a short carry chain. Operands are accepted with a start/ready handshake. The result is reported with a one-cycle done pulse plus carry, signed-overflow and zero flags.

Parameters:
WIDTH, 32, operand and result width in bits; must be a multiple of CHUNK.
CHUNK, 8, bits added per clock cycle; 1 <= CHUNK <= WIDTH.

Ports:
clk  input  1  clock; all state changes on its rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request a new operation; accepted only when ready=1.
ready  output  1  high when idle and able to accept start.
sub  input  1  0 = inp1+inp2+cin; 1 = inp1-inp2 (cin ignored).
inp1  input  WIDTH  first operand.
inp2  input  WIDTH  second operand.
cin  input  1  carry-in for add mode.
done  output  1  one-cycle pulse; result outputs are final.
sum  output  WIDTH  registered result.
cout  output  1  carry out of bit WIDTH-1; in sub mode 1 = no borrow.
overflow  output  1  signed two's-complement overflow.
zero  output  1  sum equals 0.

Behaviour:
- N = WIDTH/CHUNK, the number of chunk cycles. States are IDLE, RUN and DONE.
- Reset (rst=1 at a clock edge):
  - state becomes IDLE;
  - sum, cout, overflow, zero and done become 0;
  - internal chunk counter and carry are cleared;
  - ready=1 in the first cycle after reset.
- ready = (state==IDLE), decoded combinationally from the state register.
- IDLE:
  - If start=1 at an edge, latch inp1, effective B (= sub ? ~inp2 : inp2) and effective carry (= sub ? 1 : cin).
  - The operation mode is also latched. The counter becomes 0 and the state moves to RUN.
  - If start=0, the unit stays in IDLE and the outputs hold.
- RUN:
  - Each edge adds chunk k, meaning bits [k*CHUNK +: CHUNK] of the latched operands plus the carry register.
  - The chunk sum goes into an internal result register and the carry-out goes into the carry register. k then increments.
  - On the edge that processes chunk N-1, the state moves to DONE and the outputs are loaded:
    - sum = full result;
    - cout = final carry;
    - overflow = (A[W-1] == B[W-1]) && (sum[W-1] != A[W-1]), using the latched A and effective B;
    - zero = (result == 0).
- DONE lasts exactly one cycle with done=1 and ready=0, then the state moves to IDLE.
- Latency: start accepted at edge E; done=1 in the cycle following edge E+N. With defaults (N=4), done is high 5 cycles after the start cycle.
- sum and the flags are only written on entry to DONE. They do not change during RUN, and they hold their values until the next operation completes or rst.
- The operands inp1, inp2, cin and sub are sampled only at the accepting edge. Later changes do not affect the operation in progress.
- start while in RUN or DONE is ignored; it is not queued.
- rst during RUN or DONE aborts the operation: no done pulse, outputs cleared, state IDLE.
- CHUNK=WIDTH gives N=1 (one RUN cycle). CHUNK=1 gives a bit-serial unit with N=WIDTH.
- Arithmetic is modulo 2^WIDTH. The carry register is exactly 1 bit. Chunk additions are CHUNK+1 bits wide.

Test Plan:
- Add with wraparound, default parameters: start with inp1=32'hFFFFFFFF, inp2=1, cin=0, sub=0 -> done exactly 5 cycles after the start cycle; sum=0, cout=1, zero=1, overflow=0.
- Signed overflow: inp1=32'h7FFFFFFF, inp2=1 -> sum=32'h80000000, cout=0, overflow=1, zero=0.
- Subtract with borrow: sub=1, inp1=5, inp2=7, cin=1 (ignored) -> sum=32'hFFFFFFFE, cout=0, overflow=0. Then sub=1, inp1=32'h80000000, inp2=1 -> sum=32'h7FFFFFFF, cout=1, overflow=1.
- Handshake and operand capture:
  - Start 3+4. Pulse start again with 10+10 during RUN, and change inp1/inp2 mid-operation.
  - Expect a single done pulse with sum=7 and ready low until DONE exits.
  - The second start is never accepted; the previous sum stays stable through RUN.
- Reset mid-operation: start 100+200, assert rst on the 2nd RUN cycle -> no done pulse, sum=0, flags=0, ready=1 the next cycle. A new start of 1+1 then gives sum=2.
- Parameter sweep: WIDTH=16 with CHUNK=1, 4 and 16, using random operands and both modes against a reference model -> done latency is N+1 cycles (17, 5 and 2 respectively), and all outputs match the model.
